alu_mem_stage: RTL and testbench

- Execute and memory stage of the single-cycle MIPS datapath.
- Decodes the ALU operation from the control unit's 2-bit aluop and the instruction funct field.
- Performs the 32-bit ALU operation and accesses a word-organised data memory, using the ALU result as the address.
- Sits between the register file / immediate mux and the write-back mux.

---
 rtl/alu_mem_stage.sv | 123 ++++++++++++
 tb/tb_alu_mem_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_stage.sv
// alu_mem_stage: execute + memory stage of a single-cycle MIPS datapath.
//
// Decodes the ALU operation from aluop/func. Runs a 32-bit ALU and accesses a
// word-organised data memory addressed by the ALU result.
//
// Optional feature macro: ALU_OVERFLOW_EN
//   Defined:   signed overflow detection for ADD/SUB drives `overflow`.
//   Undefined: `overflow` is tied to 0.
//
// Ports:
//   clk        in   system clock; memory writes on rising edge
//   rst        in   asynchronous active-high reset (clears memory)
//   func       in   [5:0]  instruction funct field
//   aluop      in   [1:0]  ALU operation class from control
//   in1        in   [31:0] operand A
//   in2        in   [31:0] operand B
//   writeData  in   [31:0] store data
//   memRead    in   gates the read data output
//   memWrite   in   data memory write enable
//   aluResult  out  [31:0] ALU result / memory byte address
//   zero       out  aluResult == 0
//   overflow   out  signed overflow for ADD/SUB (when enabled)
//   dmOutData  out  [31:0] memory read data (0 when memRead=0)
module alu_mem_stage #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  func,
  input  logic [1:0]  aluop,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] aluResult,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] dmOutData
);

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluSub = 4'b0110,
    AluSlt = 4'b0111,
    AluNor = 4'b1100
  } alu_ctrl_e;

  alu_ctrl_e           alu_ctrl;
  logic [31:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]   word_idx;

  // ALU control decode
  always_comb begin
    alu_ctrl = AluAdd;
    unique case (aluop)
      2'b00: alu_ctrl = AluAdd;
      2'b01: alu_ctrl = AluSub;
      2'b11: alu_ctrl = AluOr;
      2'b10: begin
        case (func)
          6'b100000: alu_ctrl = AluAdd;
          6'b100010: alu_ctrl = AluSub;
          6'b100100: alu_ctrl = AluAnd;
          6'b100101: alu_ctrl = AluOr;
          6'b100111: alu_ctrl = AluNor;
          6'b101010: alu_ctrl = AluSlt;
          default:   alu_ctrl = AluAdd;
        endcase
      end
      default: alu_ctrl = AluAdd;
    endcase
  end

  // ALU datapath
  always_comb begin
    aluResult = 32'h0;
    case (alu_ctrl)
      AluAnd:  aluResult = in1 & in2;
      AluOr:   aluResult = in1 | in2;
      AluNor:  aluResult = ~(in1 | in2);
      AluAdd:  aluResult = in1 + in2;
      AluSub:  aluResult = in1 - in2;
      AluSlt:  aluResult = {31'h0, ($signed(in1) < $signed(in2))};
      default: aluResult = 32'h0;
    endcase
  end

  assign zero = (aluResult == 32'h0);

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    overflow = 1'b0;
    case (alu_ctrl)
      AluAdd:  overflow = (in1[31] == in2[31]) && (aluResult[31] != in1[31]);
      AluSub:  overflow = (in1[31] != in2[31]) && (aluResult[31] != in1[31]);
      default: overflow = 1'b0;
    endcase
  end
`else
  assign overflow = 1'b0;
`endif

  // Byte offset and upper address bits are dropped: addresses wrap mod DEPTH.
  assign word_idx = aluResult[ADDR_W+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (memWrite) begin
      mem_q[word_idx] <= writeData;
    end
  end

  // Combinational read; no bypass of a same-cycle write.
  assign dmOutData = memRead ? mem_q[word_idx] : 32'h0;

endmodule

// File: tb/tb_alu_mem_stage.sv
module tb_alu_mem_stage;

  localparam int unsigned Depth = 64;

  logic        clk;
  logic        rst;
  logic [5:0]  func;
  logic [1:0]  aluop;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] aluResult;
  logic        zero;
  logic        overflow;
  logic [31:0] dmOutData;

  int tests_run;
  int tests_failed;

  alu_mem_stage #(
    .DEPTH (Depth),
    .ADDR_W(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .func     (func),
    .aluop    (aluop),
    .in1      (in1),
    .in2      (in2),
    .writeData(writeData),
    .memRead  (memRead),
    .memWrite (memWrite),
    .aluResult(aluResult),
    .zero     (zero),
    .overflow (overflow),
    .dmOutData(dmOutData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_OVERFLOW_EN
  localparam logic OvfEn = 1'b1;
`else
  localparam logic OvfEn = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [5:0]  func;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Address the memory through the ALU: aluop=00 adds in1+in2.
  task automatic set_addr(input logic [31:0] addr);
    aluop = 2'b00;
    func  = 6'b000000;
    in1   = 32'h0;
    in2   = addr;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    func      = 6'h0;
    aluop     = 2'b00;
    in1       = 32'h0;
    in2       = 32'h0;
    writeData = 32'h0;
    memRead   = 1'b0;
    memWrite  = 1'b0;

    vecs[0]  = '{"add",       2'b10, 6'b100000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vecs[1]  = '{"sub_zero",  2'b10, 6'b100010, 32'd7,        32'd7,        32'd0,        1'b1, 1'b0};
    vecs[2]  = '{"slt_true",  2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
    vecs[3]  = '{"slt_false", 2'b10, 6'b101010, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
    vecs[4]  = '{"nor",       2'b10, 6'b100111, 32'h0,        32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0};
    vecs[5]  = '{"and",       2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vecs[6]  = '{"or_func",   2'b10, 6'b100101, 32'h00F0000F, 32'h0F000F00, 32'h0FF00F0F, 1'b0, 1'b0};
    vecs[7]  = '{"func_dflt", 2'b10, 6'b000011, 32'd100,      32'd23,       32'd123,      1'b0, 1'b0};
    vecs[8]  = '{"op00_add",  2'b00, 6'b100010, 32'd40,       32'd2,        32'd42,       1'b0, 1'b0};
    vecs[9]  = '{"op01_sub",  2'b01, 6'b100000, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[10] = '{"op11_or",   2'b11, 6'b100100, 32'h00000A00, 32'h00000050, 32'h00000A50, 1'b0, 1'b0};
    vecs[11] = '{"add_ovf",   2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, OvfEn};
    vecs[12] = '{"sub_ovf",   2'b01, 6'b000000, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, OvfEn};
    vecs[13] = '{"add_noovf", 2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1'b0};

    // Reset state: memory cleared, read gated on.
    #2;
    memRead = 1'b1;
    set_addr(32'd28);
    #1;
    check("reset_read", dmOutData, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ALU table
    for (int i = 0; i < 14; i++) begin
      aluop = vecs[i].aluop;
      func  = vecs[i].func;
      in1   = vecs[i].in1;
      in2   = vecs[i].in2;
      #1;
      check({vecs[i].name, "_res"}, aluResult, vecs[i].exp_res);
      check({vecs[i].name, "_zero"}, {31'h0, zero}, {31'h0, vecs[i].exp_zero});
      check({vecs[i].name, "_ovf"}, {31'h0, overflow}, {31'h0, vecs[i].exp_ovf});
    end

    // Write DEADBEEF at byte 28, then read back with memRead on/off.
    @(negedge clk);
    memRead   = 1'b0;
    set_addr(32'd28);
    writeData = 32'hDEADBEEF;
    memWrite  = 1'b1;
    @(negedge clk);
    memWrite = 1'b0;
    memRead  = 1'b1;
    #1;
    check("rd_28", dmOutData, 32'hDEADBEEF);
    memRead = 1'b0;
    #1;
    check("rd_gated", dmOutData, 32'h0);

    // Address wrap: index 1 via byte 4, read via 260 and 5.
    @(negedge clk);
    set_addr(32'd4);
    writeData = 32'h12345678;
    memWrite  = 1'b1;
    @(negedge clk);
    memWrite = 1'b0;
    memRead  = 1'b1;
    set_addr(32'd4 + 32'd4 * Depth);
    #1;
    check("rd_wrap", dmOutData, 32'h12345678);
    set_addr(32'd5);
    #1;
    check("rd_offset", dmOutData, 32'h12345678);

    // Simultaneous read+write: old value before the edge, new after.
    @(negedge clk);
    set_addr(32'd4);
    writeData = 32'hCAFEF00D;
    memWrite  = 1'b1;
    #1;
    check("rw_before", dmOutData, 32'h12345678);
    @(posedge clk);
    #1;
    check("rw_after", dmOutData, 32'hCAFEF00D);
    memWrite = 1'b0;

    // Async reset between edges clears memory immediately.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", dmOutData, 32'h0);
    // Write attempt while in reset must be blocked.
    writeData = 32'hA5A5A5A5;
    memWrite  = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wr_blk", dmOutData, 32'h0);
    memWrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_4", dmOutData, 32'h0);
    set_addr(32'd28);
    #1;
    check("post_rst_28", dmOutData, 32'h0);

    // First write after reset release lands on the next edge.
    writeData = 32'h0BADCAFE;
    memWrite  = 1'b1;
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    check("post_rst_wr", dmOutData, 32'h0BADCAFE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
